// File: rtl/fft8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft8_pkg
//  Description : Shared definitions for the 8-point FFT stream controller:
//                frame size, bin index width, controller state encoding and
//                the slot-offset helper used to pack/unpack the 8*DW buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft8_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // LSB position of slot idx inside a packed N*dw bus (slot 0 at the LSBs).
    function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_scale_round.sv
`default_nettype none
// ============================================================================
//  Module      : fft8_scale_round
//  Description : Divides one signed result component by 8 with round-half-up:
//                y_o = (y_i + 4) >>> 3, formed at DW+1 bits, truncated to DW.
//                Only instantiated when FFT8_SCALE_EN is defined.
//  Ports       : y_i  in  DW  signed component from the core
//                y_o  out DW  scaled component
//  Revision    : 1.0 - initial release
// ============================================================================
module fft8_scale_round #(
    parameter int DW = 24
) (
    input  logic signed [DW-1:0] y_i,
    output logic signed [DW-1:0] y_o
);

    logic signed [DW:0] sum;
    logic               unused_lsbs;

    // One extra bit of headroom makes the +4 rounding offset overflow-free.
    assign sum = {y_i[DW-1], y_i} + (DW+1)'(4);

    // Arithmetic shift by 3 at DW+1 bits, keeping the low DW bits.
    assign y_o = {{2{sum[DW]}}, sum[DW:3]};

    // Bits shifted out by the divide.
    assign unused_lsbs = ^sum[2:0];

endmodule
`default_nettype wire

// File: rtl/fft8_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft8_stream_ctrl
//  Description : Sequencing controller for the 8-point parallel FFT core.
//                LOAD  : collects 8 complex samples from the input stream.
//                FIRE  : pulses fft_en for one cycle.
//                WAIT  : waits up to MAX_LAT cycles for fft_valid; captures
//                        the 8 results or flags a sticky timeout.
//                DRAIN : sends y0..y7 on the output stream.
//                Optional build macro FFT8_SCALE_EN: results are divided by 8
//                (round half up) when captured; otherwise captured bit-exact.
//  Ports       : clk, rstn                  clock, async active-low reset
//                s_valid/s_ready/s_real/s_imag   input sample stream
//                fft_en, fft_x_real/imag    start pulse and frame to the core
//                fft_valid, fft_y_real/imag result handshake from the core
//                m_valid/m_ready/m_real/m_imag/m_index/m_last  output stream
//                busy                       high outside LOAD
//                err_timeout                sticky core-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fft8_stream_ctrl
    import fft8_pkg::*;
#(
    parameter int DW      = 24,
    parameter int MAX_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_real,
    input  logic signed [DW-1:0] s_imag,
    output logic                 fft_en,
    output logic [N*DW-1:0]      fft_x_real,
    output logic [N*DW-1:0]      fft_x_imag,
    input  logic                 fft_valid,
    input  logic [N*DW-1:0]      fft_y_real,
    input  logic [N*DW-1:0]      fft_y_imag,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_real,
    output logic signed [DW-1:0] m_imag,
    output logic [IDX_W-1:0]     m_index,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    state_e                state_q;
    logic [IDX_W-1:0]      cnt_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  s_ready_q;
    logic                  fft_en_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [IDX_W-1:0]      m_index_q;
    logic signed [DW-1:0]  m_real_q;
    logic signed [DW-1:0]  m_imag_q;
    logic                  busy_q;
    logic                  err_q;

    logic signed [DW-1:0]  frame_re_q [N];
    logic signed [DW-1:0]  frame_im_q [N];
    logic signed [DW-1:0]  res_re_q   [N];
    logic signed [DW-1:0]  res_im_q   [N];

    // Values written into the result buffer on capture.
    logic signed [DW-1:0]  cap_re_d   [N];
    logic signed [DW-1:0]  cap_im_d   [N];

    // ------------------------------------------------------------------------
    // Per-slot packing of the frame and unpacking (optionally scaling) of the
    // core results.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N; i++) begin : g_slot
            localparam int LSB = slot_lsb(i, DW);

            assign fft_x_real[LSB +: DW] = frame_re_q[i];
            assign fft_x_imag[LSB +: DW] = frame_im_q[i];

`ifdef FFT8_SCALE_EN
            fft8_scale_round #(.DW(DW)) u_scale_re (
                .y_i (fft_y_real[LSB +: DW]),
                .y_o (cap_re_d[i])
            );
            fft8_scale_round #(.DW(DW)) u_scale_im (
                .y_i (fft_y_imag[LSB +: DW]),
                .y_o (cap_im_d[i])
            );
`else
            assign cap_re_d[i] = fft_y_real[LSB +: DW];
            assign cap_im_d[i] = fft_y_imag[LSB +: DW];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            lat_q     <= '0;
            s_ready_q <= 1'b0;
            fft_en_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_index_q <= '0;
            m_real_q  <= '0;
            m_imag_q  <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                frame_re_q[k] <= '0;
                frame_im_q[k] <= '0;
                res_re_q[k]   <= '0;
                res_im_q[k]   <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        frame_re_q[cnt_q] <= s_real;
                        frame_im_q[cnt_q] <= s_imag;
                        // cnt_q wraps from 7 back to 0 naturally.
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (cnt_q == IDX_W'(N - 1)) begin
                            state_q   <= ST_FIRE;
                            s_ready_q <= 1'b0;
                            fft_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end

                ST_FIRE: begin
                    fft_en_q <= 1'b0;
                    lat_q    <= LAT_W'(1);
                    state_q  <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A result arriving on the deadline cycle still wins.
                    if (fft_valid) begin
                        for (int k = 0; k < N; k++) begin
                            res_re_q[k] <= cap_re_d[k];
                            res_im_q[k] <= cap_im_d[k];
                        end
                        lat_q     <= '0;
                        state_q   <= ST_DRAIN;
                        m_valid_q <= 1'b1;
                        m_index_q <= '0;
                        m_last_q  <= 1'b0;
                        // Bin 0 is presented straight from the capture path
                        // so m_* are valid in the first DRAIN cycle.
                        m_real_q  <= cap_re_d[0];
                        m_imag_q  <= cap_im_d[0];
                    end else if (lat_q == LAT_W'(MAX_LAT)) begin
                        err_q     <= 1'b1;
                        lat_q     <= '0;
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end

                ST_DRAIN: begin
                    if (m_valid_q && m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_index_q <= '0;
                            state_q   <= ST_LOAD;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            m_index_q <= m_index_q + IDX_W'(1);
                            m_real_q  <= res_re_q[m_index_q + IDX_W'(1)];
                            m_imag_q  <= res_im_q[m_index_q + IDX_W'(1)];
                            m_last_q  <= (m_index_q == IDX_W'(N - 2));
                        end
                    end
                end

                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign fft_en      = fft_en_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_index     = m_index_q;
    assign m_real      = m_real_q;
    assign m_imag      = m_imag_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft8_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft8_stream_ctrl
//  Description : Directed self-checking bench for fft8_stream_ctrl with a
//                behavioural 8-point DFT core stub (programmable latency,
//                optional no-response and spurious-valid modes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft8_stream_ctrl;

    localparam int DW      = 24;
    localparam int MAX_LAT = 8;

    logic                 clk;
    logic                 rstn;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_real;
    logic [DW-1:0]        s_imag;
    logic                 fft_en;
    logic [8*DW-1:0]      fft_x_real;
    logic [8*DW-1:0]      fft_x_imag;
    logic                 fft_valid;
    logic [8*DW-1:0]      fft_y_real;
    logic [8*DW-1:0]      fft_y_imag;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_real;
    logic signed [DW-1:0] m_imag;
    logic [2:0]           m_index;
    logic                 m_last;
    logic                 busy;
    logic                 err_timeout;

    int n_vec = 0;
    int n_err = 0;

    int stub_lat  = 3;
    bit stub_dead = 1'b0;
    bit spur_req  = 1'b0;
    int stub_cnt  = 0;

    fft8_stream_ctrl #(.DW(DW), .MAX_LAT(MAX_LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_imag      (s_imag),
        .fft_en      (fft_en),
        .fft_x_real  (fft_x_real),
        .fft_x_imag  (fft_x_imag),
        .fft_valid   (fft_valid),
        .fft_y_real  (fft_y_real),
        .fft_y_imag  (fft_y_imag),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_real      (m_real),
        .m_imag      (m_imag),
        .m_index     (m_index),
        .m_last      (m_last),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Core stub
    // ------------------------------------------------------------------------
    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic stub_compute();
        real ar, ai, th;
        int  xr, xi;
        for (int k = 0; k < 8; k++) begin
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < 8; n++) begin
                th = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
                xr = $signed(fft_x_real[n*DW +: DW]);
                xi = $signed(fft_x_imag[n*DW +: DW]);
                ar = ar + real'(xr) * $cos(th) + real'(xi) * $sin(th);
                ai = ai + real'(xi) * $cos(th) - real'(xr) * $sin(th);
            end
            fft_y_real[k*DW +: DW] = DW'(rnd(ar));
            fft_y_imag[k*DW +: DW] = DW'(rnd(ai));
        end
    endtask

    always @(negedge clk) begin
        fft_valid = 1'b0;
        if (spur_req) begin
            fft_valid  = 1'b1;
            fft_y_real = {8{24'h3C3C3C}};
            fft_y_imag = {8{24'hC3C3C3}};
        end else if (fft_en && !stub_dead) begin
            stub_compute();
            stub_cnt = stub_lat;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) fft_valid = 1'b1;
        end
    end

    // Expected capture transform for the current build.
    function automatic int expv(input int v);
`ifdef FFT8_SCALE_EN
        return (v + 4) >>> 3;
`else
        return v;
`endif
    endfunction

    // ------------------------------------------------------------------------
    // Stream helpers (entered and left on a falling edge)
    // ------------------------------------------------------------------------
    task automatic send_frame(input int xr[8], input int xi[8]);
        bit ok;
        int g;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_real  = DW'(xr[i]);
            s_imag  = DW'(xi[i]);
            g = 0;
            do begin
                ok = s_ready;
                @(negedge clk);
                g++;
            end while (!ok && g < 50);
            if (!ok) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout sample=%0d s_ready=%b required=1", i, s_ready);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag, input int er[8], input int ei[8],
                               input bit bp, input int nbins);
        int bin, cyc, ph;
        bit held;
        logic signed [DW-1:0] h_r, h_i, e_r, e_i;
        logic [2:0] h_x;
        bin = 0; cyc = 0; ph = 0; held = 1'b0;
        h_r = '0; h_i = '0; h_x = '0;
        while (bin < nbins && cyc < 300) begin
            m_ready = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            if (m_valid) begin
                ph++;
                if (held) begin
                    n_vec++;
                    if (m_real !== h_r || m_imag !== h_i || m_index !== h_x) begin
                        n_err++;
                        $display("FAIL %s_stall_hold got=%0d/%0d/%0d required=%0d/%0d/%0d",
                                 tag, m_real, m_imag, m_index, h_r, h_i, h_x);
                    end
                end
                if (m_ready) begin
                    e_r = DW'(expv(er[bin]));
                    e_i = DW'(expv(ei[bin]));
                    n_vec++;
                    if (m_real !== e_r || m_imag !== e_i) begin
                        n_err++;
                        $display("FAIL %s_data bin=%0d got=%0d,%0d required=%0d,%0d",
                                 tag, bin, m_real, m_imag, e_r, e_i);
                    end
                    n_vec++;
                    if (m_index !== 3'(bin) || m_last !== (bin == 7)) begin
                        n_err++;
                        $display("FAIL %s_index bin=%0d got idx=%0d last=%b required idx=%0d last=%b",
                                 tag, bin, m_index, m_last, bin, (bin == 7));
                    end
                    n_vec++;
                    if (s_ready !== 1'b0 || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL %s_drain_flags bin=%0d got s_ready=%b busy=%b required 0,1",
                                 tag, bin, s_ready, busy);
                    end
                    bin++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h_r = m_real; h_i = m_imag; h_x = m_index;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (bin < nbins) begin
            n_vec++; n_err++;
            $display("FAIL %s_drain_timeout got bins=%0d required=%0d", tag, bin, nbins);
        end else if (nbins == 8) begin
            n_vec++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s_end got m_valid=%b s_ready=%b busy=%b required 0,1,0",
                         tag, m_valid, s_ready, busy);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 || fft_en !== 1'b0 ||
            err_timeout !== 1'b0 || m_index !== 3'd0 || m_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b busy=%b mv=%b en=%b err=%b idx=%0d last=%b required all 0",
                     s_ready, busy, m_valid, fft_en, err_timeout, m_index, m_last);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got=%b required=1", s_ready);
        end
    endtask

    task automatic test_impulse(input string tag);
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
        xi = '{default: 0};
        er = '{default: 1000};
        ei = '{default: 0};
        send_frame(xr, xi);
        n_vec++;
        if (fft_en !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_fire got en=%b rdy=%b busy=%b required 1,0,1", tag, fft_en, s_ready, busy);
        end
        drain_check(tag, er, ei, 1'b0, 8);
    endtask

    task automatic test_dc();
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        xr = '{default: 8};
        xi = '{default: 0};
        er = '{64, 0, 0, 0, 0, 0, 0, 0};
        ei = '{default: 0};
        send_frame(xr, xi);
        drain_check("dc", er, ei, 1'b0, 8);
    endtask

    task automatic test_backpressure();
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        xr = '{0, 1000, 0, 0, 0, 0, 0, 0};
        xi = '{default: 0};
        er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        ei = '{0, -707, -1000, -707, 0, 707, 1000, 707};
        send_frame(xr, xi);
        drain_check("bp", er, ei, 1'b1, 8);
    endtask

    task automatic test_capture_tie();
        stub_lat = MAX_LAT;
        test_impulse("tie");
        n_vec++;
        if (err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tie_no_error got err=%b required=0", err_timeout);
        end
        stub_lat = 3;
    endtask

    task automatic test_timeout();
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        bit saw_mv;
        xr = '{default: 5};
        xi = '{default: -3};
        stub_dead = 1'b1;
        send_frame(xr, xi);
        saw_mv = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (m_valid) saw_mv = 1'b1;
            if (k == 8) begin
                n_vec++;
                if (err_timeout !== 1'b0 || s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_early got err=%b rdy=%b required 0,0", err_timeout, s_ready);
                end
            end
        end
        n_vec++;
        if (err_timeout !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || saw_mv) begin
            n_err++;
            $display("FAIL timeout_flag got err=%b rdy=%b busy=%b mv_seen=%b required 1,1,0,0",
                     err_timeout, s_ready, busy, saw_mv);
        end
        stub_dead = 1'b0;
        xr = '{default: 8};
        xi = '{default: 0};
        er = '{64, 0, 0, 0, 0, 0, 0, 0};
        ei = '{default: 0};
        send_frame(xr, xi);
        drain_check("post_timeout", er, ei, 1'b0, 8);
        n_vec++;
        if (err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky got=%b required=1", err_timeout);
        end
    endtask

    task automatic test_spurious();
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        @(posedge clk);
        #1 spur_req = 1'b1;
        @(posedge clk);
        #1 spur_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_ignored got mv=%b rdy=%b busy=%b required 0,1,0", m_valid, s_ready, busy);
        end
        xr = '{0, 1000, 0, 0, 0, 0, 0, 0};
        xi = '{default: 0};
        er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        ei = '{0, -707, -1000, -707, 0, 707, 1000, 707};
        send_frame(xr, xi);
        drain_check("spur", er, ei, 1'b0, 8);
    endtask

    task automatic test_reset_mid_drain();
        int xr[8]; int xi[8]; int er[8]; int ei[8];
        xr = '{1000, 0, 0, 0, 0, 0, 0, 0};
        xi = '{default: 0};
        er = '{default: 1000};
        ei = '{default: 0};
        send_frame(xr, xi);
        drain_check("mid", er, ei, 1'b0, 4);
        rstn = 1'b0;
        #1;
        n_vec++;
        if (m_valid !== 1'b0 || m_index !== 3'd0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset got mv=%b idx=%0d busy=%b err=%b required 0,0,0,0",
                     m_valid, m_index, busy, err_timeout);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_release_ready got=%b required=1", s_ready);
        end
        test_impulse("fresh");
    endtask

    initial begin
        rstn       = 1'b0;
        s_valid    = 1'b0;
        s_real     = '0;
        s_imag     = '0;
        m_ready    = 1'b0;
        fft_valid  = 1'b0;
        fft_y_real = '0;
        fft_y_imag = '0;

        test_reset();
        test_impulse("impulse");
        test_dc();
        test_backpressure();
        test_capture_tie();
        test_timeout();
        test_spurious();
        test_reset_mid_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
